ge_program_sequencer: RTL and testbench

Sequential executor for evolved bitwise-register programs. Holds a loadable instruction list, loads four 16-bit working registers from the operand inputs, and applies one register-to-register bitwise operation per clock. It then presents the final register file as results through a valid/ready handshake. It lets one datapath evaluate any individual's program at run time instead of synthesising one module per individual.

---
 rtl/ge_seq_pkg.sv | 27 ++
 rtl/ge_program_sequencer_if.sv | 34 +++
 rtl/ge_reg_alu.sv | 29 ++
 rtl/ge_program_sequencer.sv | 116 +++++++++++
 tb/tb_ge_program_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ge_seq_pkg.sv
// Shared types for the evolved-program sequencer: opcodes, instruction
// encoding, FSM states and register-file size.
package ge_seq_pkg;

    localparam int NREG = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    // 6-bit instruction word {op, dst, src}.
    typedef struct packed {
        op_e        op;
        logic [1:0] dst;
        logic [1:0] src;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ge_program_sequencer_if.sv
// Program-load port plus operand/result handshake of the sequencer.
// master = producer/consumer side, slave = the sequencer.
interface ge_program_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int MAX_INSTR = 16
) ();
    localparam int AW = $clog2(MAX_INSTR);

    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [5:0]       prog_data;
    logic [AW:0]      prog_len;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a1, a0, b1, b0;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y3, y2, y1, y0;
    logic             busy;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len,
        output in_valid, a1, a0, b1, b0, out_ready,
        input  in_ready, out_valid, y3, y2, y1, y0, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len,
        input  in_valid, a1, a0, b1, b0, out_ready,
        output in_ready, out_valid, y3, y2, y1, y0, busy
    );
endinterface

// File: rtl/ge_reg_alu.sv
// Combinational register-file update: applies one bitwise instruction
// to the 4-entry register file and returns the whole next file.
module ge_reg_alu
    import ge_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [NREG-1:0][WIDTH-1:0] regs_i,
    input  instr_t                     instr_i,
    output logic [NREG-1:0][WIDTH-1:0] regs_o
);
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] dst_val;

    assign src_val = regs_i[instr_i.src];
    assign dst_val = regs_i[instr_i.dst];

    // Only the destination register changes; dst == src falls out naturally.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        regs_o = regs_i;
        unique case (instr_i.op)
            OP_AND: regs_o[instr_i.dst] = dst_val & src_val;
            OP_OR:  regs_o[instr_i.dst] = dst_val | src_val;
            OP_XOR: regs_o[instr_i.dst] = dst_val ^ src_val;
            OP_MOV: regs_o[instr_i.dst] = src_val;
        endcase
    end
endmodule

// File: rtl/ge_program_sequencer.sv
// Sequential executor for evolved bitwise-register programs: loads four
// registers from the operands, runs len instructions one per clock, then
// holds the register file as results until the consumer accepts them.
module ge_program_sequencer
    import ge_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_INSTR = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ge_program_sequencer_if.slave  bus
);
    localparam int          AW      = $clog2(MAX_INSTR);
    localparam logic [AW:0] LEN_MAX = (AW + 1)'(MAX_INSTR);

    typedef logic [NREG-1:0][WIDTH-1:0] regfile_t;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    regfile_t      regs_q, regs_d, regs_alu;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;

    instr_t        mem_q [MAX_INSTR];
    instr_t        cur_instr;
    logic [AW:0]   accept_len;
    logic          prog_wr_en;

    assign cur_instr  = mem_q[pc_q];
    assign accept_len = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;

    // Writes land in IDLE or on the DONE->IDLE edge. The accepting cycle is
    // excluded: the run starting there reads mem[0] on the very next cycle.
    assign prog_wr_en = bus.prog_we &&
                        (((state_q == S_IDLE) && !bus.in_valid) ||
                         ((state_q == S_DONE) && bus.out_ready));

    ge_reg_alu #(.WIDTH(WIDTH)) u_alu (
        .regs_i  (regs_q),
        .instr_i (cur_instr),
        .regs_o  (regs_alu)
    );

    // Next-state logic for the IDLE/EXEC/DONE controller and register file.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        regs_d  = regs_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    regs_d  = {bus.b1, bus.b0, bus.a1, bus.a0};
                    len_d   = accept_len;
                    pc_d    = '0;
                    state_d = (accept_len != '0) ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                regs_d = regs_alu;
                pc_d   = pc_q + 1'b1;
                if ({1'b0, pc_q} == len_q - 1'b1) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE);
    end

    // Controller state, counters, register file and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            regs_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Program memory: synchronous write, combinational read by pc.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the program store must come up as all-AND r0,r0, so it is a reset flop array, not a RAM.
        if (!rst_n) begin
            for (int i = 0; i < MAX_INSTR; i++) mem_q[i] <= '0;
        end else if (prog_wr_en) begin
            mem_q[bus.prog_addr] <= instr_t'(bus.prog_data);
        end
    end

    assign bus.y0        = regs_q[0];
    assign bus.y1        = regs_q[1];
    assign bus.y2        = regs_q[2];
    assign bus.y3        = regs_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_ge_program_sequencer.sv
// Directed self-checking bench for ge_program_sequencer.
module tb_ge_program_sequencer;
    localparam int WIDTH     = 16;
    localparam int MAX_INSTR = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    ge_program_sequencer_if #(.WIDTH(WIDTH), .MAX_INSTR(MAX_INSTR)) bus ();

    ge_program_sequencer #(.WIDTH(WIDTH), .MAX_INSTR(MAX_INSTR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_instr(input int addr, input logic [1:0] op,
                               input logic [1:0] dst, input logic [1:0] src);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'(addr);
        bus.prog_data = {op, dst, src};
        step();
        bus.prog_we   = 1'b0;
    endtask

    // Accept one operand set, then count edges until out_valid (bounded).
    task automatic run(input int len, input logic [15:0] a1, input logic [15:0] a0,
                       input logic [15:0] b1, input logic [15:0] b0, output int n);
        bus.prog_len = 5'(len);
        bus.a1 = a1; bus.a0 = a0; bus.b1 = b1; bus.b0 = b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic release_done();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_y(input string tag, input logic [15:0] e3, input logic [15:0] e2,
                           input logic [15:0] e1, input logic [15:0] e0);
        check({tag, ".y3"}, 32'(bus.y3), 32'(e3));
        check({tag, ".y2"}, 32'(bus.y2), 32'(e2));
        check({tag, ".y1"}, 32'(bus.y1), 32'(e1));
        check({tag, ".y0"}, 32'(bus.y0), 32'(e0));
    endtask

    task automatic load_test1_prog();
        write_instr(0, 2'b00, 2'd0, 2'd3);  // AND r0,r3
        write_instr(1, 2'b01, 2'd1, 2'd0);  // OR  r1,r0
        write_instr(2, 2'b00, 2'd1, 2'd3);  // AND r1,r3
        write_instr(3, 2'b10, 2'd2, 2'd3);  // XOR r2,r3
        write_instr(4, 2'b00, 2'd3, 2'd0);  // AND r3,r0
    endtask

    initial begin
        rst_n = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.prog_len = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a1 = '0; bus.a0 = '0; bus.b1 = '0; bus.b0 = '0;
        #12 rst_n = 1'b1;
        #1;

        // Reset state
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check_y("rst", 16'h0, 16'h0, 16'h0, 16'h0);

        // Test 1: five-instruction program
        load_test1_prog();
        run(5, 16'h00FF, 16'h0F0F, 16'h3333, 16'h5555, lat);
        check("t1.latency", 32'(lat), 32'd5);
        check_y("t1", 16'h0303, 16'h6666, 16'h0333, 16'h0303);
        check("t1.busy", 32'(bus.busy), 32'd1);
        check("t1.in_ready", 32'(bus.in_ready), 32'd0);
        release_done();
        check("t1.rel.out_valid", 32'(bus.out_valid), 32'd0);
        check("t1.rel.in_ready", 32'(bus.in_ready), 32'd1);
        check("t1.rel.y3_hold", 32'(bus.y3), 32'h0303);

        // Test 2: zero-length program, out_valid at the accept edge
        run(0, 16'h1234, 16'hABCD, 16'hFFFF, 16'h0000, lat);
        check("t2.latency", 32'(lat), 32'd0);
        check_y("t2", 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD);
        release_done();

        // Test 3: DONE held for 10 cycles while in_valid/prog_we toggle;
        // a write during the accept cycle must not disturb this run.
        bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = {2'b11, 2'd0, 2'd1};
        run(5, 16'h00FF, 16'h0F0F, 16'h3333, 16'h5555, lat);
        bus.prog_we = 1'b0;
        check("t3.latency", 32'(lat), 32'd5);
        check_y("t3.first", 16'h0303, 16'h6666, 16'h0333, 16'h0303);
        load_test1_prog_restore: begin end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = i[0];
            bus.prog_we   = ~i[0];
            bus.prog_addr = 4'(i % 5);
            bus.prog_data = 6'b11_00_01;
            bus.a0 = 16'hDEAD; bus.b1 = 16'hBEEF;
            step();
            check("t3.hold.y0", 32'(bus.y0), 32'h0303);
            check("t3.hold.y2", 32'(bus.y2), 32'h6666);
            check("t3.hold.in_ready", 32'(bus.in_ready), 32'd0);
            check("t3.hold.out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0; bus.prog_we = 1'b0;
        release_done();
        // Restore slot 0 in case the accept-cycle write was stored, then rerun.
        write_instr(0, 2'b00, 2'd0, 2'd3);
        run(5, 16'h00FF, 16'h0F0F, 16'h3333, 16'h5555, lat);
        check("t3.rerun.latency", 32'(lat), 32'd5);
        check_y("t3.rerun", 16'h0303, 16'h6666, 16'h0333, 16'h0303);
        release_done();

        // Test 4: dst == src XOR clears; MOV copies
        write_instr(0, 2'b10, 2'd1, 2'd1);  // XOR r1,r1
        run(1, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333, lat);
        check("t4.xor.latency", 32'(lat), 32'd1);
        check_y("t4.xor", 16'h2222, 16'h3333, 16'h0000, 16'h1111);
        release_done();
        write_instr(0, 2'b11, 2'd0, 2'd2);  // MOV r0,r2
        run(1, 16'h0001, 16'h0002, 16'h0003, 16'h5A5A, lat);
        check("t4.mov.latency", 32'(lat), 32'd1);
        check_y("t4.mov", 16'h0003, 16'h5A5A, 16'h0001, 16'h5A5A);
        release_done();

        // Test 5: reset mid-EXEC at pc=2
        bus.prog_len = 5'd5;
        bus.a1 = 16'h00FF; bus.a0 = 16'h0F0F; bus.b1 = 16'h3333; bus.b0 = 16'h5555;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("t5.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5.rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("t5.rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("t5.rst.busy", 32'(bus.busy), 32'd0);
        check_y("t5.rst", 16'h0, 16'h0, 16'h0, 16'h0);
        #2 rst_n = 1'b1;
        run(1, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1, lat);
        check("t5.rerun.latency", 32'(lat), 32'd1);
        check_y("t5.rerun", 16'hACE0, 16'hBDF1, 16'h1357, 16'h2468);
        release_done();

        // Test 6: prog_len saturates at MAX_INSTR
        for (int i = 0; i < MAX_INSTR; i++) write_instr(i, 2'b11, 2'd3, 2'd0);  // MOV r3,r0
        run(MAX_INSTR + 5, 16'h1111, 16'hC0DE, 16'h2222, 16'h3333, lat);
        check("t6.latency", 32'(lat), 32'(MAX_INSTR));
        check_y("t6", 16'hC0DE, 16'h3333, 16'h1111, 16'hC0DE);
        release_done();
        check("t6.rel.in_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
